// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state type and default bus widths for mem_ctrl_rr
package mem_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
endpackage

// File: rtl/mem_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant of the first requester at or after the pointer
module rr_arbiter #(
    parameter  int NUM_CH = 2,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);
    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int               j;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
        gnt = found ? (NUM_CH'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else if (advance) ptr_q <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: rtl/mem_ctrl_rr.sv
// mem_ctrl_rr: NUM_CH requesters share one single-port memory core via round-robin arbitration
module mem_ctrl_rr
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 256,
    parameter int NUM_CH = 2,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        cmd_valid,
    input  logic [NUM_CH-1:0]        we_sys,
    input  logic [NUM_CH*ADDR_W-1:0] addr_sys,
    input  logic [NUM_CH*DATA_W-1:0] wdata_sys,
    output logic [NUM_CH-1:0]        ready_sys,
    output logic                     err_sys,
    output logic [DATA_W-1:0]        rdata_sys,
    output logic                     ce_mem,
    output logic                     we_mem,
    output logic [ADDR_W-1:0]        addr_mem,
    output logic [DATA_W-1:0]        datai_mem,
    input  logic [DATA_W-1:0]        datao_mem
);
    localparam int              IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              CNT_W = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    logic [NUM_CH-1:0] gnt, gnt_q;
    logic [IDX_W-1:0]  gnt_idx;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q, err_q, in_range, advance;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel_addr  = addr_sys[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata_sys[gnt_idx*DATA_W +: DATA_W];
    assign in_range  = {1'b0, sel_addr} < LIMIT;
    assign advance   = (state_q == IDLE) && |cmd_valid;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (cmd_valid),
        .advance (advance),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Memory strobes are loaded on IDLE exit so they are live for exactly the ACCESS cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            ready_sys <= '0;
            err_sys   <= 1'b0;
            rdata_sys <= '0;
            ce_mem    <= 1'b0;
            we_mem    <= 1'b0;
            addr_mem  <= '0;
            datai_mem <= '0;
        end else begin
            case (state_q)
                IDLE: if (advance) begin
                    state_q   <= ACCESS;
                    gnt_q     <= gnt;
                    we_q      <= we_sys[gnt_idx];
                    err_q     <= !in_range;
                    ce_mem    <= in_range;
                    we_mem    <= in_range && we_sys[gnt_idx];
                    addr_mem  <= in_range ? sel_addr : '0;
                    datai_mem <= in_range ? sel_wdata : '0;
                end
                ACCESS: begin
                    ce_mem    <= 1'b0;
                    we_mem    <= 1'b0;
                    addr_mem  <= '0;
                    datai_mem <= '0;
                    if (!err_q && !we_q) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_W'(RD_LAT);
                    end else begin
                        state_q   <= RESP;
                        ready_sys <= gnt_q;
                        err_sys   <= err_q;
                        if (err_q) rdata_sys <= '0;
                    end
                end
                WAIT: if (cnt_q == CNT_W'(1)) begin
                    state_q   <= RESP;
                    rdata_sys <= datao_mem;
                    ready_sys <= gnt_q;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: begin
                    state_q   <= IDLE;
                    ready_sys <= '0;
                    err_sys   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl_rr.sv
// tb_mem_ctrl_rr: randomized rounds of requests against a transaction-level model and scoreboard
module tb_mem_ctrl_rr;
    localparam int DW = 8, AW = 8, DEP = 200, NCH = 3, RL = 3;

    logic             clk = 0, reset = 1;
    logic [NCH-1:0]   cmd_valid = '0, we_sys = '0, ready_sys;
    logic [NCH*AW-1:0] addr_sys = '0;
    logic [NCH*DW-1:0] wdata_sys = '0;
    logic             err_sys, ce_mem, we_mem;
    logic [DW-1:0]    rdata_sys, datai_mem, datao_mem;
    logic [AW-1:0]    addr_mem;

    typedef struct {int ch; bit err; logic [7:0] rdata; int cyc;} rsp_t;
    typedef struct {bit we; logic [7:0] addr; logic [7:0] data; int cyc;} mop_t;

    rsp_t       exp_q[$];
    mop_t       mop_q[$];
    rsp_t       e;
    mop_t       m;
    int         checks = 0, errors = 0, cyc = 0;
    int         rr_ptr = 0, last_rdy = -100;
    logic [7:0] last_rdata = '0;
    logic [7:0] core [256];
    logic [7:0] ref_mem [256];
    logic [7:0] rd_d [RL];
    logic       rd_v [RL];
    logic [7:0] junk = '0;

    mem_ctrl_rr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_CH(NCH), .RD_LAT(RL)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .we_sys    (we_sys),
        .addr_sys  (addr_sys),
        .wdata_sys (wdata_sys),
        .ready_sys (ready_sys),
        .err_sys   (err_sys),
        .rdata_sys (rdata_sys),
        .ce_mem    (ce_mem),
        .we_mem    (we_mem),
        .addr_mem  (addr_mem),
        .datai_mem (datai_mem),
        .datao_mem (datao_mem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory core: read data valid exactly RL cycles after the strobe, junk otherwise
    always @(posedge clk) begin
        if (ce_mem && we_mem) core[addr_mem] <= datai_mem;
        rd_v[0] <= ce_mem && !we_mem;
        rd_d[0] <= core[addr_mem];
        for (int i = 1; i < RL; i++) begin
            rd_v[i] <= rd_v[i-1];
            rd_d[i] <= rd_d[i-1];
        end
        junk <= 8'($urandom);
    end
    assign datao_mem = rd_v[RL-1] ? rd_d[RL-1] : junk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int next_grant(input logic [NCH-1:0] pend, input int ptr);
        for (int k = 0; k < NCH; k++) if (pend[(ptr + k) % NCH]) return (ptr + k) % NCH;
        return 0;
    endfunction

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 8'd199;
            1: return 8'd200;
            2: return 8'd255;
            3: return 8'($urandom);
            default: return 8'($urandom_range(0, 7));
        endcase
    endfunction

    always @(negedge clk) begin
        if (ready_sys != '0) begin
            check("ready_onehot", 32'($onehot(ready_sys)), 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=%b required=none cycle=%0d", ready_sys, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ready_ch", 32'(ready_sys), 32'(1 << e.ch));
                check("err_sys", 32'(err_sys), 32'(e.err));
                check("rdata_sys", 32'(rdata_sys), 32'(e.rdata));
                check("ready_cycle", cyc, e.cyc);
            end
        end else check("err_idle", 32'(err_sys), 0);
        if (ce_mem) begin
            if (mop_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ce actual=%0h required=none cycle=%0d", addr_mem, cyc);
            end else begin
                m = mop_q.pop_front();
                check("we_mem", 32'(we_mem), 32'(m.we));
                check("addr_mem", 32'(addr_mem), 32'(m.addr));
                check("datai_mem", 32'(datai_mem), 32'(m.data));
                check("ce_cycle", cyc, m.cyc);
            end
        end else check("mem_idle", {we_mem, addr_mem, datai_mem}, 0);
    end

    task automatic run_round(input logic [NCH-1:0] set, input bit fixed, input bit fwe,
                             input logic [7:0] faddr, input logic [7:0] fdata);
        bit         ops_we [NCH];
        logic [7:0] ops_a [NCH];
        logic [7:0] ops_d [NCH];
        logic [NCH-1:0] pend, done;
        int         t, g, budget;
        bit         er;
        for (int ch = 0; ch < NCH; ch++) if (set[ch]) begin
            ops_we[ch] = fixed ? fwe : 1'($urandom_range(0, 1));
            ops_a[ch]  = fixed ? faddr : pick_addr();
            ops_d[ch]  = fixed ? fdata : 8'($urandom);
            cmd_valid[ch] = 1'b1;
            we_sys[ch]    = ops_we[ch];
            addr_sys[ch*AW +: AW]  = ops_a[ch];
            wdata_sys[ch*DW +: DW] = ops_d[ch];
        end
        pend = set;
        t = (cyc > last_rdy + 1) ? cyc : last_rdy + 1;
        while (pend != '0) begin
            g = next_grant(pend, rr_ptr);
            pend[g] = 1'b0;
            rr_ptr = (g + 1) % NCH;
            er = ops_a[g] >= DEP;
            if (!er) mop_q.push_back('{ops_we[g], ops_a[g], ops_d[g], t + 1});
            if (er) last_rdata = '0;
            else if (!ops_we[g]) last_rdata = ref_mem[ops_a[g]];
            else ref_mem[ops_a[g]] = ops_d[g];
            last_rdy = t + ((er || ops_we[g]) ? 2 : 2 + RL);
            exp_q.push_back('{g, er, last_rdata, last_rdy});
            t = last_rdy + 1;
        end
        done = '0;
        budget = 0;
        while ((done & set) != set && budget < 80) begin
            @(negedge clk);
            budget++;
            for (int ch = 0; ch < NCH; ch++) if (ready_sys[ch] && set[ch] && !done[ch]) begin
                done[ch] = 1'b1;
                cmd_valid[ch] = 1'b0;
                we_sys[ch] = 1'($urandom);
                addr_sys[ch*AW +: AW]  = 8'($urandom);
                wdata_sys[ch*DW +: DW] = 8'($urandom);
            end
        end
        if ((done & set) != set) begin
            checks++;
            errors++;
            $display("FAIL round_timeout actual=%b required=%b", done, set);
            cmd_valid = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) begin
            core[i]    = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < RL; i++) rd_v[i] = 1'b0;
        #1 reset = 0;
        #2 check("reset_outputs", {ready_sys, err_sys, rdata_sys, ce_mem, we_mem, addr_mem, datai_mem}, 0);
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        run_round(3'b001, 1, 1, 8'h10, 8'hA5);
        run_round(3'b001, 1, 0, 8'h10, 8'h00);
        run_round(3'b001, 1, 1, 8'h3C, 8'h3C);
        run_round(3'b001, 1, 0, 8'h3C, 8'h00);
        run_round(3'b001, 1, 0, 8'hF0, 8'h00);
        run_round(3'b001, 1, 0, 8'd199, 8'h00);
        run_round(3'b001, 1, 1, 8'd200, 8'h11);
        run_round(3'b011, 1, 0, 8'h10, 8'h00);
        run_round(3'b011, 1, 1, 8'h05, 8'h5A);
        run_round(3'b010, 1, 0, 8'h05, 8'h00);
        run_round(3'b111, 0, 0, 8'h00, 8'h00);
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_round(3'($urandom_range(1, 7)), 0, 0, 8'h00, 8'h00);
        end
        run_round(3'b001, 1, 1, 8'h3C, 8'h77);
        run_round(3'b001, 1, 0, 8'h3C, 8'h00);
        // Read on ch1 that reset aborts while the core is still in its latency window
        cmd_valid[1] = 1'b1;
        we_sys[1] = 1'b0;
        addr_sys[AW +: AW] = 8'h3C;
        t = (cyc > last_rdy + 1) ? cyc : last_rdy + 1;
        mop_q.push_back('{1'b0, 8'h3C, wdata_sys[DW +: DW], t + 1});
        while (cyc < t + 3) @(negedge clk);
        reset = 0;
        #1 check("reset_async", {ready_sys, err_sys, rdata_sys, ce_mem, we_mem, addr_mem, datai_mem}, 0);
        cmd_valid = '0;
        repeat (3) @(negedge clk) check("no_ready_in_reset", 32'(ready_sys), 0);
        reset = 1;
        rr_ptr = 0;
        last_rdy = -100;
        last_rdata = '0;
        repeat (6) @(negedge clk) check("no_ready_after_drop", 32'(ready_sys), 0);
        run_round(3'b110, 1, 0, 8'h3C, 8'h00);
        run_round(3'b010, 1, 0, 8'h3C, 8'h00);
        repeat (5) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("mop_q_empty", mop_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
